// File: rtl/tb_mmio_monitor.sv
// Passive MMIO monitor for the data-side bus: captures console bytes from
// NUM_CH channels into a tagged FIFO and reports end-of-test status.
//
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   data_req_i/gnt_i/we_i      request, grant and write enable of the snooped bus
//   data_be_i, data_addr_i     byte enables and byte address
//   data_wdata_i               write data
//   char_valid_o/ready_i       FIFO head handshake towards the bench
//   char_data_o, char_ch_o     head byte and its channel tag
//   drop_cnt_o                 bytes lost on a full FIFO (saturating)
//   done_o, pass_o             test finished with FIFO drained, pass flag
//   exit_code_o                latched exit code
//   timeout_o                  idle timeout was the termination cause
module tb_mmio_monitor #(
    parameter logic [31:0] ADDR_BASE   = 32'h8004_0000,
    parameter int unsigned NUM_CH      = 2,
    parameter logic [31:0] EXIT_OFFSET = 32'h0000_0100,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            data_req_i,
    input  logic            data_gnt_i,
    input  logic            data_we_i,
    input  logic [3:0]      data_be_i,
    input  logic [31:0]     data_addr_i,
    input  logic [31:0]     data_wdata_i,
    output logic            char_valid_o,
    input  logic            char_ready_i,
    output logic [7:0]      char_data_o,
    output logic [CH_W-1:0] char_ch_o,
    output logic [15:0]     drop_cnt_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [31:0]     exit_code_o,
    output logic            timeout_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDLE_W = 32;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [7:0]      data;
    } char_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Address decode of granted writes
    // ------------------------------------------------------------------
    logic            wr_ev;
    logic [31:0]     offset;
    logic            con_hit;
    logic            con_push;
    logic            con_stop;
    logic            exit_hit;
    logic            any_ev;
    logic [CH_W-1:0] con_ch;
    logic            unused_be;

    assign wr_ev    = data_req_i & data_gnt_i & data_we_i;
    assign offset   = data_addr_i - ADDR_BASE;
    assign con_hit  = wr_ev && data_be_i[0] && (offset[1:0] == 2'b00)
                      && ({2'b00, offset[31:2]} < 32'(NUM_CH));
    assign con_push = con_hit && !data_wdata_i[7];
    assign con_stop = con_hit && data_wdata_i[7];
    assign exit_hit = wr_ev && (data_addr_i == ADDR_BASE + EXIT_OFFSET);
    assign any_ev   = con_hit | exit_hit;
    assign con_ch   = offset[CH_W+1:2];
    // exit writes accept any byte-enable pattern, so the upper enables carry no meaning
    assign unused_be = ^data_be_i[3:1];

    // ------------------------------------------------------------------
    // Console FIFO with registered head outputs
    // ------------------------------------------------------------------
    char_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             accept_push;
    logic             full;
    logic             pop;
    logic             push_req;
    logic             push_ok;
    logic             drop;
    char_entry_t      new_entry;
    char_entry_t      head_d;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = char_valid_o & char_ready_i;
    assign push_req  = accept_push && con_push;
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign new_entry = '{ch: con_ch, data: data_wdata_i[7:0]};

    // Next occupancy, read pointer and head entry; a push landing in the slot
    // the read pointer moves to bypasses the not-yet-written memory.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        head_d   = '{ch: char_ch_o, data: char_data_o};
        if (count_d != '0) begin
            head_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? new_entry : mem[rd_ptr_d];
        end
    end

    // Storage array, no reset needed: contents are only read behind count
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    // Pointers, count, head outputs and drop counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            char_valid_o <= 1'b0;
            char_data_o  <= '0;
            char_ch_o    <= '0;
            drop_cnt_o   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            char_valid_o <= (count_d != '0);
            char_data_o  <= head_d.data;
            char_ch_o    <= head_d.ch;
            if (drop && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Termination FSM
    // ------------------------------------------------------------------
    state_e            state_q;
    state_e            state_d;
    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;
    logic              tmo_hit;
    logic [31:0]       code_d;
    logic              pass_d;
    logic              tmo_d;
    logic              done_d;

    // Fires on the cycle that would bring the idle count to TIMEOUT_CYC
    assign tmo_hit = (TIMEOUT_CYC != 0) && !any_ev
                     && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (exit_hit || con_stop || tmo_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Output logic: push gating, idle counting and cause latching (events beat timeout)
    always_comb begin
        accept_push = 1'b0;
        idle_d      = '0;
        code_d      = exit_code_o;
        pass_d      = pass_o;
        tmo_d       = timeout_o;
        done_d      = (state_d == DONE);
        if (state_q == RUN) begin
            accept_push = 1'b1;
            idle_d      = any_ev ? '0 : (idle_q + IDLE_W'(1));
            if (exit_hit) begin
                code_d = data_wdata_i;
                pass_d = (data_wdata_i == 32'h0);
            end else if (con_stop) begin
                code_d = {25'b0, data_wdata_i[6:0]};
                pass_d = (data_wdata_i[6:0] == 7'h0);
            end else if (tmo_hit) begin
                code_d = 32'hFFFF_FFFF;
                pass_d = 1'b0;
                tmo_d  = 1'b1;
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idle_q      <= '0;
            exit_code_o <= '0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            idle_q      <= idle_d;
            exit_code_o <= code_d;
            pass_o      <= pass_d;
            timeout_o   <= tmo_d;
            done_o      <= done_d;
        end
    end

endmodule

// File: tb/tb_tb_mmio_monitor.sv
// Bench for tb_mmio_monitor: queue-based reference model, scoreboard for the
// console stream, directed scenarios plus randomized bus traffic.
module tb_tb_mmio_monitor;

    localparam logic [31:0] BASE     = 32'h8004_0000;
    localparam int unsigned NCH      = 2;
    localparam logic [31:0] EXIT_OFF = 32'h0000_0100;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TMO      = 50;
    localparam int unsigned CHW      = 1;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           req = 1'b0;
    logic           gnt = 1'b0;
    logic           we = 1'b0;
    logic [3:0]     be = 4'h0;
    logic [31:0]    addr = 32'h0;
    logic [31:0]    wdata = 32'h0;
    logic           ready = 1'b0;
    logic           char_valid;
    logic [7:0]     char_data;
    logic [CHW-1:0] char_ch;
    logic [15:0]    drop_cnt;
    logic           done;
    logic           pass;
    logic [31:0]    exit_code;
    logic           timeout;

    always #5 clk = ~clk;

    tb_mmio_monitor #(
        .ADDR_BASE  (BASE),
        .NUM_CH     (NCH),
        .EXIT_OFFSET(EXIT_OFF),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .data_req_i  (req),
        .data_gnt_i  (gnt),
        .data_we_i   (we),
        .data_be_i   (be),
        .data_addr_i (addr),
        .data_wdata_i(wdata),
        .char_valid_o(char_valid),
        .char_ready_i(ready),
        .char_data_o (char_data),
        .char_ch_o   (char_ch),
        .drop_cnt_o  (drop_cnt),
        .done_o      (done),
        .pass_o      (pass),
        .exit_code_o (exit_code),
        .timeout_o   (timeout)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: expected FIFO occupancy as a queue, termination as
    // a three-phase status, expected console stream pushed to the scoreboard.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  data;
        int unsigned ch;
    } ent_t;
    typedef enum {M_RUN, M_DRAIN, M_DONE} mst_e;

    ent_t        mq[$];
    ent_t        sb[$];
    mst_e        mst = M_RUN;
    int unsigned mdrop = 0;
    int unsigned midle = 0;
    logic [31:0] mcode = 32'h0;
    logic        mpass = 1'b0;
    logic        mtmo = 1'b0;

    always @(posedge clk) begin : model
        logic        wr, con, ex, stop, pop;
        logic [31:0] off;
        ent_t        e;
        if (!rstn) begin
            mq.delete();
            sb.delete();
            mst   = M_RUN;
            mdrop = 0;
            midle = 0;
            mcode = 32'h0;
            mpass = 1'b0;
            mtmo  = 1'b0;
        end else begin
            wr     = req && gnt && we;
            off    = addr - BASE;
            con    = wr && be[0] && (off % 4 == 0) && (off / 4 < NCH);
            ex     = wr && (addr == BASE + EXIT_OFF);
            stop   = con && wdata[7];
            pop    = (mq.size() > 0) && ready;
            e.data = wdata[7:0];
            e.ch   = off / 4;
            case (mst)
                M_RUN: begin
                    if (con && !stop) begin
                        if (mq.size() < DEPTH || pop) begin
                            mq.push_back(e);
                            sb.push_back(e);
                        end else if (mdrop < 32'hFFFF) begin
                            mdrop++;
                        end
                    end
                    if (ex) begin
                        mcode = wdata;
                        mpass = (wdata == 32'h0);
                        mst   = M_DRAIN;
                    end else if (stop) begin
                        mcode = {25'b0, wdata[6:0]};
                        mpass = (wdata[6:0] == 7'h0);
                        mst   = M_DRAIN;
                    end else if (con) begin
                        midle = 0;
                    end else begin
                        midle++;
                        if (TMO != 0 && midle == TMO) begin
                            mcode = 32'hFFFF_FFFF;
                            mpass = 1'b0;
                            mtmo  = 1'b1;
                            mst   = M_DRAIN;
                        end
                    end
                end
                M_DRAIN: if (mq.size() == 0) mst = M_DONE;
                default: ;
            endcase
            if (pop) void'(mq.pop_front());
        end
    end

    // Monitor on the falling edge: reset values, status vs model, stream vs scoreboard
    always @(negedge clk) begin : monitor
        ent_t e;
        if (!rstn) begin
            chk("rst_valid", 32'(char_valid), 32'h0);
            chk("rst_data", 32'(char_data), 32'h0);
            chk("rst_ch", 32'(char_ch), 32'h0);
            chk("rst_drop", 32'(drop_cnt), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_pass", 32'(pass), 32'h0);
            chk("rst_code", exit_code, 32'h0);
            chk("rst_timeout", 32'(timeout), 32'h0);
        end else begin
            chk("valid", 32'(char_valid), 32'(mq.size() != 0));
            chk("done", 32'(done), 32'(mst == M_DONE));
            chk("timeout", 32'(timeout), 32'(mtmo));
            chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
            if (mst == M_DONE) begin
                chk("pass", 32'(pass), 32'(mpass));
                chk("exit_code", exit_code, mcode);
            end
            if (char_valid && ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_extra: got byte 0x%0h, expected no byte", char_data);
                end else begin
                    e = sb.pop_front();
                    chk("char_data", 32'(char_data), 32'(e.data));
                    chk("char_ch", 32'(char_ch), 32'(e.ch));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: every bus call occupies exactly one cycle
    // ------------------------------------------------------------------
    logic ready_level = 1'b0;
    bit   ready_rand  = 1'b0;

    task automatic bus(input logic r, input logic g, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        req   = r;
        gnt   = g;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
        ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic cwr(input int unsigned ch, input logic [7:0] d);
        bus(1'b1, 1'b1, 1'b1, 4'h1, BASE + 32'(4 * ch), {24'h0, d});
    endtask

    task automatic xwr(input logic [31:0] d);
        bus(1'b1, 1'b1, 1'b1, 4'hF, BASE + EXIT_OFF, d);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2;
        rstn        = 1'b0;
        req         = 1'b0;
        gnt         = 1'b0;
        we          = 1'b0;
        ready       = 1'b0;
        ready_level = 1'b0;
        ready_rand  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!done && i < budget) begin
            idle(1);
            i++;
        end
        n_chk++;
        if (done) n_pass++;
        else $display("FAIL wait_done: done_o=0 after %0d cycles, expected 1", budget);
        chk("sb_drained", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;

        // Two bytes on channel 0, one-cycle latency, ready held high
        do_reset();
        ready_level = 1'b1;
        idle(1);
        cwr(0, 8'h41);
        cwr(0, 8'h42);
        chk("s1_head_a", 32'(char_data), 32'h41);
        chk("s1_valid_a", 32'(char_valid), 32'h1);
        idle(1);
        chk("s1_head_b", 32'(char_data), 32'h42);
        idle(1);
        chk("s1_empty", 32'(char_valid), 32'h0);
        cwr(0, 8'h80);
        wait_done(10);
        chk("s1_pass", 32'(pass), 32'h1);
        chk("s1_code", exit_code, 32'h0);

        // Channel 1 tag, and no push without byte enable 0
        do_reset();
        idle(1);
        cwr(1, 8'h43);
        bus(1'b1, 1'b1, 1'b1, 4'b0010, BASE + 32'h4, 32'h44);
        chk("s2_head", 32'(char_data), 32'h43);
        chk("s2_ch", 32'(char_ch), 32'h1);
        ready_level = 1'b1;
        idle(3);
        chk("s2_no_be0", 32'(char_valid), 32'h0);
        xwr(32'h0);
        wait_done(10);

        // Overflow: 18 writes into 16 entries, then drain across pointer wrap
        do_reset();
        idle(1);
        for (int i = 0; i < 18; i++) cwr(i % 2, 8'(i));
        idle(1);
        chk("s3_drop", 32'(drop_cnt), 32'h2);
        chk("s3_head", 32'(char_data), 32'h0);
        ready_level = 1'b1;
        idle(4);
        for (int i = 0; i < 10; i++) cwr(i % 2, 8'(8'h60 + 8'(i)));
        idle(30);
        chk("s3_empty", 32'(char_valid), 32'h0);
        xwr(32'h0);
        wait_done(10);

        // Stop with bytes queued: done waits for the drain
        do_reset();
        idle(1);
        cwr(0, 8'h31);
        cwr(1, 8'h32);
        cwr(0, 8'h33);
        cwr(0, 8'h80);
        idle(5);
        chk("s4_not_done", 32'(done), 32'h0);
        cwr(1, 8'h55);
        idle(2);
        ready_level = 1'b1;
        wait_done(20);
        chk("s4_pass", 32'(pass), 32'h1);
        chk("s4_code", exit_code, 32'h0);
        chk("s4_drop", 32'(drop_cnt), 32'h0);
        cwr(0, 8'h66);
        idle(3);
        chk("s4_ignored", 32'(char_valid), 32'h0);

        // Exit register; a read and an ungranted write first have no effect
        do_reset();
        bus(1'b1, 1'b1, 1'b0, 4'hF, BASE + EXIT_OFF, 32'h7);
        bus(1'b1, 1'b0, 1'b1, 4'hF, BASE + EXIT_OFF, 32'h9);
        idle(2);
        chk("s5_not_done", 32'(done), 32'h0);
        xwr(32'h5);
        wait_done(10);
        chk("s5_pass", 32'(pass), 32'h0);
        chk("s5_code", exit_code, 32'h5);
        chk("s5_timeout", 32'(timeout), 32'h0);

        // Idle timeout after exactly 50 cycles
        do_reset();
        ready_level = 1'b1;
        idle(49);
        chk("s6_timeout_early", 32'(timeout), 32'h0);
        idle(1);
        chk("s6_timeout", 32'(timeout), 32'h1);
        wait_done(5);
        chk("s6_pass", 32'(pass), 32'h0);
        chk("s6_code", exit_code, 32'hFFFF_FFFF);

        // Reset while draining discards queued bytes
        do_reset();
        idle(1);
        cwr(0, 8'h11);
        cwr(1, 8'h12);
        idle(55);
        chk("s7_timeout", 32'(timeout), 32'h1);
        chk("s7_draining", 32'(done), 32'h0);
        chk("s7_valid", 32'(char_valid), 32'h1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("s7_rst_valid", 32'(char_valid), 32'h0);
        chk("s7_rst_timeout", 32'(timeout), 32'h0);
        chk("s7_rst_code", exit_code, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rstn        = 1'b1;
        ready_level = 1'b1;
        idle(3);
        chk("s7_discarded", 32'(char_valid), 32'h0);
        xwr(32'h0);
        wait_done(10);

        // Randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            ready_rand = 1'b1;
            for (int c = 0; c < 150; c++) begin
                int unsigned k, ch;
                k  = $urandom_range(0, 99);
                ch = $urandom_range(0, 1);
                if (k < 45)
                    bus(1'b1, 1'b1, 1'b1, 4'($urandom) | 4'h1, BASE + 32'(4 * ch),
                        32'($urandom_range(0, 127)));
                else if (k < 50)
                    bus(1'b1, 1'b1, 1'b1, 4'b1110, BASE + 32'(4 * ch), 32'h5A);
                else if (k < 55)
                    bus(1'b1, 1'b1, 1'b1, 4'h1, BASE + 32'h8, 32'h21);
                else if (k < 60)
                    bus(1'b1, 1'b1, 1'b1, 4'h1, BASE + 32'h1, 32'h22);
                else if (k < 68)
                    bus(1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'(4 * ch), 32'h80);
                else if (k < 76)
                    bus(1'b1, 1'b0, 1'b1, 4'hF, BASE + 32'(4 * ch), 32'h23);
                else if (k < 77)
                    bus(1'b1, 1'b1, 1'b1, 4'h1, BASE + 32'(4 * ch),
                        32'h80 | 32'($urandom_range(0, 3)));
                else if (k < 78)
                    bus(1'b1, 1'b1, 1'b1, 4'($urandom), BASE + EXIT_OFF,
                        ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
                else
                    idle(1);
            end
            ready_rand  = 1'b0;
            ready_level = 1'b1;
            xwr(($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
            wait_done(100);
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tb_mmio_monitor.md
Name: tb_mmio_monitor

Overview:
- Bus-snooping end-of-test and console monitor for the cheriot testbench.
- Passively observes the data-side request/grant bus.
- Captures console byte writes from NUM_CH channels into a tagged FIFO, drained by the bench via valid/ready.
- Detects test completion (console stop bit or dedicated exit register) and idle timeout, and reports pass/fail with an exit code.

Parameters:
- ADDR_BASE, 32'h8004_0000, base of monitored MMIO region.
- NUM_CH, 2, number of console channels (1..16); channel c at ADDR_BASE + 4*c.
- EXIT_OFFSET, 32'h100, offset of exit register from ADDR_BASE.
- FIFO_DEPTH, 16, console FIFO entries (power of 2, >=2).
- TIMEOUT_CYC, 1000000, idle cycles before timeout; 0 disables.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- data_req_i  in  1  data request
- data_gnt_i  in  1  data grant
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- char_valid_o  out  1  FIFO head valid
- char_ready_i  in  1  bench accepts head
- char_data_o  out  8  head byte
- char_ch_o  out  $clog2(NUM_CH) (min 1)  head channel tag
- drop_cnt_o  out  16  bytes dropped on full FIFO, saturating
- done_o  out  1  test finished, FIFO drained
- pass_o  out  1  valid when done_o
- exit_code_o  out  32  valid when done_o
- timeout_o  out  1  idle timeout occurred

Behaviour:
- Monitored write (event): data_req_i & data_gnt_i & data_we_i in the same cycle. Reads and ungranted requests are ignored.
- Console event:
  - Condition: addr == ADDR_BASE + 4*c, c < NUM_CH, and data_be_i[0]=1.
  - wdata[7]=0: push {c, wdata[7:0]}.
  - wdata[7]=1: stop request, no push; exit code = {25'b0, wdata[6:0]}, pass = (wdata[6:0]==0).
- Exit event: addr == ADDR_BASE + EXIT_OFFSET, any data_be_i. Exit code = wdata[31:0], pass = (wdata==0).
- Addresses in the region not matching the rules above are ignored and do not reset the idle counter.
- FIFO:
  - Registered pointers plus count.
  - Push at the event edge; char_valid_o rises the next cycle when the FIFO was empty.
  - Pop on char_valid_o & char_ready_i.
  - Push while full is accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and drop_cnt_o increments, saturating at 16'hFFFF.
  - Pointers wrap modulo FIFO_DEPTH.
  - Outputs are stable while valid & !ready.
- FSM, states RUN, DRAIN, DONE:
  - RUN: accepts pushes. A console stop or exit event latches code/pass and goes to DRAIN.
  - RUN: idle counter increments each cycle and clears on any monitored event. When it reaches TIMEOUT_CYC (if nonzero), latch code 32'hFFFF_FFFF, pass=0, set timeout_o, go to DRAIN.
  - DRAIN: pushes are ignored (not counted as drops) and no further code is latched. Go to DONE in the cycle the FIFO count is 0. done_o is registered, so it is high the cycle after count==0 is seen.
  - DONE: terminal; done_o=1 held. Further events are ignored.
- Simultaneous events:
  - Console push and stop in the same cycle are impossible (one address per cycle).
  - The first latched termination cause wins. A timeout coinciding with an exit event yields the exit event (event priority), and timeout_o stays 0.
- Reset (async, any state): FSM=RUN, FIFO empty, char_valid_o=0, char_data_o=0, char_ch_o=0, drop_cnt_o=0, done_o=0, pass_o=0, exit_code_o=0, timeout_o=0, idle counter=0.
  - Reset mid-DRAIN discards FIFO contents.

Test Plan:
- Write 0x41 then 0x42 to 0x8004_0000, ready held 1 -> char_valid_o pulses for 'A' then 'B', ch=0, in order, 1-cycle latency.
- NUM_CH=2, write 0x43 to 0x8004_0004 -> char_data_o=0x43, char_ch_o=1. Same write with be=4'b0010 -> no push.
- Hold ready 0, write 18 bytes with FIFO_DEPTH=16 -> 16 retained, drop_cnt_o=2. Then raise ready -> 16 bytes out in order across pointer wrap.
- 3 bytes queued with ready 0, then write 0x80 to the console address -> done_o stays 0 until all 3 are popped, then done_o=1, pass_o=1, exit_code_o=0. A later byte write is ignored.
- Write 32'h0000_0005 to 0x8004_0100 -> done_o=1, pass_o=0, exit_code_o=5. A read (we=0) to the same address beforehand has no effect.
- TIMEOUT_CYC=50, no events -> timeout_o=1 after 50 idle cycles, then done_o=1, pass_o=0, exit_code_o=32'hFFFF_FFFF. Assert reset mid-DRAIN -> all outputs return to 0.
